// File: rtl/mem_stage_sram_ctrl.sv
// Memory-access stage controller.
// Splits each 32-bit word load/store into two 16-bit accesses on a wait-state SRAM.
// The low half goes first, then the high half. The pipeline is frozen until the
// one-cycle DONE state.
//
//   state | meaning
//   IDLE  | no access in flight; sample rd_en/wr_en, address, wr_data
//   LOW   | low half-word (half=0) held on the bus for WAIT_CYCLES cycles
//   HIGH  | high half-word (half=1) held on the bus for WAIT_CYCLES cycles
//   DONE  | access complete, ready=1 for one cycle so the pipeline advances
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;

  logic [31:0] offset;
  logic        req;
  logic        last;
  logic        half;
  logic        latch_req;
  logic        cap_lo;
  logic        cap_hi;
  logic        unused_offset_bits;

  // Below-base addresses simply wrap through the modular subtraction.
  assign offset = address - 32'(ADDR_BASE);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign req    = rd_en | wr_en;
  assign last   = (cnt == CNT_LAST);
  assign freeze = req & ~ready;
  assign sram_addr = {word, half};

  // State and wait counter registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and bus/handshake outputs. Outputs are decoded from state,
  // so an asynchronous reset releases the bus in the same cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready      = 1'b0;
    half       = 1'b0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_dq_o  = '0;
    latch_req  = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          latch_req = 1'b1;
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        half       = 1'b0;
        sram_dq_oe = op_wr;
        sram_we_n  = ~op_wr;
        sram_dq_o  = op_wr ? wdata[15:0] : 16'h0000;
        if (last) begin
          cap_lo    = ~op_wr;
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        half       = 1'b1;
        sram_dq_oe = op_wr;
        sram_we_n  = ~op_wr;
        sram_dq_o  = op_wr ? wdata[31:16] : 16'h0000;
        if (last) begin
          cap_hi    = ~op_wr;
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: op, word address and store data are frozen for the whole access.
  // A simultaneous rd_en/wr_en is treated as a store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr <= 1'b0;
      word  <= '0;
      wdata <= '0;
    end else if (latch_req) begin
      op_wr <= wr_en;
      word  <= offset[18:2];
      wdata <= wr_data;
    end
  end

  // Load result assembly; each half is taken on the last cycle of its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      if (cap_lo) rd_data[15:0]  <= sram_dq_i;
      if (cap_hi) rd_data[31:16] <= sram_dq_i;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: async SRAM model, a transaction-level
// reference model, and a single negedge compare process.
module tb_mem_stage_sram_ctrl;

  localparam int W    = 5;
  localparam int BASE = 1024;
  localparam int MEMN = 262144;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, wr_data = '0;
  logic [31:0] rd_data;
  logic        ready, freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;

  mem_stage_sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .freeze(freeze),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM seen by the DUT, and the reference model's own view of memory.
  logic [15:0] sram    [0:MEMN-1];
  logic [15:0] ref_mem [0:MEMN-1];
  assign sram_dq_i = sram[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_o;

  int tests = 0, fails = 0;
  int cyc = 0, t_seq = 0, last_ready = -1;
  int freeze_cnt = 0, we_low_cnt = 0;
  logic [17:0] addr_first, addr_second;

  // Model expectations for the current cycle.
  bit          chk_on = 0;
  int          exp_k = -1;
  logic        exp_ready, exp_freeze, exp_we_n, exp_oe, exp_addr_on;
  logic [17:0] exp_addr;
  logic [15:0] exp_dq;
  logic [31:0] exp_rd;
  logic [31:0] model_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Single compare process.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", {31'b0, ready}, {31'b0, exp_ready});
      check("freeze", {31'b0, freeze}, {31'b0, exp_freeze});
      check("we_n", {31'b0, sram_we_n}, {31'b0, exp_we_n});
      check("dq_oe", {31'b0, sram_dq_oe}, {31'b0, exp_oe});
      check("rd_data", rd_data, exp_rd);
      if (exp_addr_on) check("sram_addr", {14'b0, sram_addr}, {14'b0, exp_addr});
      if (exp_oe) check("dq_o", {16'b0, sram_dq_o}, {16'b0, exp_dq});
      if (freeze) freeze_cnt++;
      if (!sram_we_n) we_low_cnt++;
      if (ready && (rd_en || wr_en)) last_ready = cyc - t_seq;
      if (exp_k == 1) addr_first = sram_addr;
      if (exp_k == W + 1) addr_second = sram_addr;
    end
  end

  task automatic set_idle_exp();
    exp_k = -1; exp_ready = 1'b1; exp_freeze = 1'b0; exp_we_n = 1'b1;
    exp_oe = 1'b0; exp_addr_on = 1'b0; exp_addr = '0; exp_dq = '0; exp_rd = model_rd;
  endtask

  task automatic idle(input int n);
    rd_en = 0; wr_en = 0;
    set_idle_exp();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One access, called at posedge+1 of the cycle in which the request is first seen.
  // abort_k >= 0 pulses reset in that cycle of the access.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int abort_k);
    logic [31:0] old, newv;
    logic [16:0] w;
    bit          is_wr;
    int          act;
    w     = 17'(((a - 32'(BASE)) >> 2) & 32'h1FFFF);
    is_wr = wr;
    old   = model_rd;
    newv  = {ref_mem[{w, 1'b1}], ref_mem[{w, 1'b0}]};
    rd_en = rd; wr_en = wr; address = a; wr_data = d;
    for (int k = 0; k <= 2 * W + 1; k++) begin
      if (k > 0) begin
        address = $urandom; wr_data = $urandom;
      end
      if (k == abort_k) begin
        rst = 0; rd_en = 0; wr_en = 0;
        #1;
        check("abort_we_n", {31'b0, sram_we_n}, 32'd1);
        check("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        // Halves finished before the abort are already in the SRAM.
        ref_mem[{w, 1'b0}] = d[15:0];
        if (k > W + 1) ref_mem[{w, 1'b1}] = d[31:16];
        model_rd = '0;
        set_idle_exp();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        return;
      end
      act         = (k >= 1 && k <= 2 * W) ? 1 : 0;
      exp_k       = k;
      exp_ready   = (k == 2 * W + 1);
      exp_freeze  = (k <= 2 * W);
      exp_oe      = is_wr && act != 0;
      exp_we_n    = !(is_wr && act != 0);
      exp_addr_on = (act != 0);
      exp_addr    = {w, (k > W) ? 1'b1 : 1'b0};
      exp_dq      = (k <= W) ? d[15:0] : d[31:16];
      if (!is_wr && k > W && k <= 2 * W) exp_rd = {old[31:16], newv[15:0]};
      else if (!is_wr && k == 2 * W + 1) exp_rd = newv;
      else exp_rd = old;
      @(posedge clk); #1;
    end
    if (is_wr) begin
      ref_mem[{w, 1'b0}] = d[15:0];
      ref_mem[{w, 1'b1}] = d[31:16];
    end else begin
      model_rd = newv;
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int op;
    for (int i = 0; i < MEMN; i++) begin
      sram[i] = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[0] = 16'h1234; ref_mem[0] = 16'h1234;
    sram[1] = 16'hABCD; ref_mem[1] = 16'hABCD;

    // Reset state.
    set_idle_exp();
    chk_on = 1;
    @(posedge clk); #1;
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_we_n", {31'b0, sram_we_n}, 32'd1);
    check("reset_addr", {14'b0, sram_addr}, 32'd0);
    check("reset_dq_o", {16'b0, sram_dq_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    idle(2);

    // Read 0x400.
    freeze_cnt = 0; t_seq = cyc;
    run_txn(1, 0, 32'h400, 32'h0, -1);
    check("t1_rd_data", rd_data, 32'hABCD1234);
    check("t1_freeze_cycles", freeze_cnt, 32'd11);
    check("t1_ready_cycle", last_ready, 32'd11);
    idle(1);

    // Write 0x404.
    we_low_cnt = 0;
    run_txn(0, 1, 32'h404, 32'hDEADBEEF, -1);
    check("t2_sram2", {16'b0, sram[2]}, 32'h0000BEEF);
    check("t2_sram3", {16'b0, sram[3]}, 32'h0000DEAD);
    check("t2_we_low_cycles", we_low_cnt, 32'd10);
    idle(1);

    // Read and write together -> write only.
    run_txn(1, 1, 32'h408, 32'h55AA55AA, -1);
    check("t3_rd_data_held", rd_data, 32'hABCD1234);
    check("t3_sram4", {16'b0, sram[4]}, 32'h000055AA);
    check("t3_sram5", {16'b0, sram[5]}, 32'h000055AA);
    idle(1);

    // Below-base wrap.
    run_txn(1, 0, 32'h3FC, 32'h0, -1);
    check("t4_addr_low", {14'b0, addr_first}, 32'h3FFFE);
    check("t4_addr_high", {14'b0, addr_second}, 32'h3FFFF);
    idle(1);

    // Back-to-back write then read of 0x400.
    t_seq = cyc;
    run_txn(0, 1, 32'h400, 32'hCAFEF00D, -1);
    run_txn(1, 0, 32'h400, 32'h0, -1);
    check("t6_ready_cycle", last_ready, 32'd23);
    check("t6_rd_data", rd_data, 32'hCAFEF00D);
    idle(1);

    // Reset during HIGH of a write.
    run_txn(0, 1, 32'h410, 32'h0BADC0DE, W + 2);
    check("t5_rd_data_after", rd_data, 32'd0);
    idle(2);
    run_txn(1, 0, 32'h410, 32'h0, -1);
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = 32'(BASE) - 32'(4 * $urandom_range(1, 4));
      else a = 32'(BASE) + 32'(4 * $urandom_range(0, 63));
      d = $urandom;
      run_txn(op != 1, op != 0, a, d, -1);
      idle($urandom_range(0, 2));
    end

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
